// File: rtl/wb_pkg.sv
// Shared widths and constants for the write-back register file and its scoreboard.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per GPR, raising hazard on RAW/WAW conflicts.
module reg_scoreboard
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              hazard,
  output logic              iss_ok
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_effBusy;
  logic [NREGS-1:0] w_busyNext;

  // A write-back landing this cycle releases its register for same-cycle readers.
  always_comb begin
    w_effBusy = r_busy;
    if (wb_en) begin
      w_effBusy[wb_addr] = 1'b0;
    end
  end

  assign hazard = iss_en & (w_effBusy[ra_addr] | w_effBusy[rb_addr] | w_effBusy[iss_dst]);
  assign iss_ok = iss_en & ~hazard;

  // Set is applied after clear so a new producer keeps the register busy.
  always_comb begin
    w_busyNext = r_busy;
    if (wb_en) begin
      w_busyNext[wb_addr] = 1'b0;
    end
    if (iss_ok && (iss_dst != REG_ZERO)) begin
      w_busyNext[iss_dst] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

endmodule

// File: rtl/wb_regfile16x16.sv
// 16x16 GPR file with two registered, write-through read ports and a hazard scoreboard.
module wb_regfile16x16
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              hazard,
  output logic              iss_ok
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_raData;
  logic [DATA_W-1:0] r_rbData;
  logic [DATA_W-1:0] w_raNext;
  logic [DATA_W-1:0] w_rbNext;
  logic              w_wbLive;

  assign w_wbLive = wb_en && (wb_addr != REG_ZERO);

  // r0 reads zero outright; otherwise a same-cycle write-back overrides the stored value.
  always_comb begin
    w_raNext = r_regs[ra_addr];
    w_rbNext = r_regs[rb_addr];
    if (w_wbLive && (wb_addr == ra_addr)) begin
      w_raNext = wb_data;
    end
    if (w_wbLive && (wb_addr == rb_addr)) begin
      w_rbNext = wb_data;
    end
    if (ra_addr == REG_ZERO) begin
      w_raNext = '0;
    end
    if (rb_addr == REG_ZERO) begin
      w_rbNext = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_raData <= '0;
      r_rbData <= '0;
    end else begin
      if (w_wbLive) begin
        r_regs[wb_addr] <= wb_data;
      end
      r_raData <= w_raNext;
      r_rbData <= w_rbNext;
    end
  end

  assign ra_data = r_raData;
  assign rb_data = r_rbData;

  reg_scoreboard uScoreboard (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .iss_en  (iss_en),
    .iss_dst (iss_dst),
    .hazard  (hazard),
    .iss_ok  (iss_ok)
  );

endmodule

// File: tb/tb_wb_regfile16x16.sv
// Directed bench for wb_regfile16x16: stimulus queues expected outputs, a monitor checks them.
module tb_wb_regfile16x16;

  logic        clk;
  logic        reset;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic        iss_en;
  logic [3:0]  iss_dst;
  logic        hazard;
  logic        iss_ok;

  typedef struct {
    int          due;
    int          sig;
    logic [15:0] exp;
    string       name;
  } expItem_t;

  expItem_t expQ[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  wb_regfile16x16 dut (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .iss_en  (iss_en),
    .iss_dst (iss_dst),
    .hazard  (hazard),
    .iss_ok  (iss_ok)
  );

  // Free-running clock and a cycle index that advances on every rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sample(int sig);
    case (sig)
      0:       return ra_data;
      1:       return rb_data;
      2:       return {15'd0, hazard};
      default: return {15'd0, iss_ok};
    endcase
  endfunction

  // Monitor: on each falling edge, retire every expectation due in this cycle.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].due <= cyc) begin
      expItem_t it;
      logic [15:0] act;
      it = expQ.pop_front();
      act = sample(it.sig);
      checkOutput(it.name, act, it.exp, it.due == cyc);
    end
  end

  task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp, bit onTime);
    checks++;
    if (!onTime) begin
      errors++;
      $display("[TB] FAIL %s: expectation missed its cycle (actual %h, required %h)", name, act, exp);
    end else if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  task automatic expectNow(int sig, logic [15:0] exp, string name);
    expQ.push_back('{due: cyc, sig: sig, exp: exp, name: name});
  endtask

  task automatic expectNext(int sig, logic [15:0] exp, string name);
    expQ.push_back('{due: cyc + 1, sig: sig, exp: exp, name: name});
  endtask

  // Drives one cycle's worth of inputs shortly after the rising edge.
  task automatic applyStimulus(bit rst, bit we, logic [3:0] wa, logic [15:0] wd,
                               logic [3:0] ra, logic [3:0] rb, bit ie, logic [3:0] dst);
    @(posedge clk);
    #1;
    reset   = rst;
    wb_en   = we;
    wb_addr = wa;
    wb_data = wd;
    ra_addr = ra;
    rb_addr = rb;
    iss_en  = ie;
    iss_dst = dst;
  endtask

  initial begin
    reset = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ra_addr = '0; rb_addr = '0; iss_en = 1'b0; iss_dst = '0;

    applyStimulus(1, 0, 0, 16'h0000, 0, 0, 0, 0);
    expectNext(0, 16'h0000, "reset_ra");
    expectNext(1, 16'h0000, "reset_rb");

    applyStimulus(0, 1, 3, 16'hBEEF, 3, 0, 0, 0);
    expectNext(0, 16'hBEEF, "wr_r3_bypass_ra");
    expectNext(1, 16'h0000, "wr_r3_rb_r0");

    applyStimulus(0, 0, 0, 16'h0000, 3, 3, 0, 0);
    expectNext(0, 16'hBEEF, "rd_r3_ra");
    expectNext(1, 16'hBEEF, "rd_r3_rb");

    applyStimulus(0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
    expectNext(0, 16'h0000, "wr_r0_bypass_ra");
    expectNext(1, 16'h0000, "wr_r0_bypass_rb");

    applyStimulus(0, 0, 0, 16'h0000, 0, 3, 0, 0);
    expectNext(0, 16'h0000, "rd_r0_ra");
    expectNext(1, 16'hBEEF, "rd_r3_rb_again");

    applyStimulus(0, 1, 5, 16'h1234, 5, 5, 0, 0);
    expectNext(0, 16'h1234, "bypass_r5_ra");
    expectNext(1, 16'h1234, "bypass_r5_rb");

    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 1, 7);
    expectNow(2, 16'd0, "iss7_hazard");
    expectNow(3, 16'd1, "iss7_ok");

    applyStimulus(0, 0, 0, 16'h0000, 7, 0, 1, 1);
    expectNow(2, 16'd1, "raw7_hazard");
    expectNow(3, 16'd0, "raw7_ok");

    applyStimulus(0, 1, 7, 16'h00AA, 7, 0, 1, 1);
    expectNow(2, 16'd0, "raw7_wb_hazard");
    expectNow(3, 16'd1, "raw7_wb_ok");
    expectNext(0, 16'h00AA, "raw7_wb_bypass_ra");

    applyStimulus(0, 0, 0, 16'h0000, 1, 0, 1, 2);
    expectNow(2, 16'd1, "raw1_hazard");
    expectNow(3, 16'd0, "raw1_ok");

    applyStimulus(0, 0, 0, 16'h0000, 1, 0, 0, 2);
    expectNow(2, 16'd0, "noiss_hazard");
    expectNow(3, 16'd0, "noiss_ok");

    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 1, 9);
    expectNow(3, 16'd1, "iss9_ok");

    applyStimulus(0, 1, 9, 16'h5555, 0, 0, 1, 9);
    expectNow(2, 16'd0, "collide9_hazard");
    expectNow(3, 16'd1, "collide9_ok");

    applyStimulus(0, 0, 0, 16'h0000, 9, 0, 1, 3);
    expectNow(2, 16'd1, "collide9_still_busy");
    expectNow(3, 16'd0, "collide9_blocked");

    applyStimulus(0, 1, 1, 16'h1111, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 16'h0000, 1, 0, 1, 3);
    expectNow(2, 16'd0, "clr1_hazard");
    expectNow(3, 16'd1, "clr1_ok");
    expectNext(0, 16'h1111, "clr1_rd_r1");

    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 1, 2);
    expectNow(3, 16'd1, "iss2_ok");

    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 1, 4);
    expectNow(3, 16'd1, "iss4_ok");

    applyStimulus(1, 1, 2, 16'hABCD, 2, 4, 1, 6);
    expectNext(0, 16'h0000, "midreset_ra");
    expectNext(1, 16'h0000, "midreset_rb");

    applyStimulus(0, 0, 0, 16'h0000, 2, 9, 1, 4);
    expectNow(2, 16'd0, "postreset_hazard");
    expectNow(3, 16'd1, "postreset_ok");
    expectNext(0, 16'h0000, "postreset_r2");
    expectNext(1, 16'h0000, "postreset_r9");

    applyStimulus(0, 0, 0, 16'h0000, 5, 3, 1, 4);
    expectNow(2, 16'd1, "waw4_hazard");
    expectNow(3, 16'd0, "waw4_ok");
    expectNext(0, 16'h0000, "postreset_r5");
    expectNext(1, 16'h0000, "postreset_r3");

    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0, 0);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
